sram_port_arbiter: RTL

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter_if.sv | 38 +++
 rtl/sram_port_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter_if.sv
// Request/response bundle between N_CH requesters, the SRAM port arbiter and one SRAM port.
// The arbiter takes the slave modport. The environment driving requesters and memory takes the master modport.
interface sram_port_arbiter_if #(
  parameter int N_CH = 2,
  parameter int AW   = 32,
  parameter int DW   = 64
);
  logic [N_CH-1:0]        req_valid;
  logic [N_CH-1:0]        req_ready;
  logic [N_CH*AW-1:0]     req_addr;
  logic [N_CH-1:0]        req_wen;
  logic [N_CH*DW-1:0]     req_wdata;
  logic [N_CH*DW/8-1:0]   req_wstrb;
  logic [N_CH-1:0]        rsp_valid;
  logic [DW-1:0]          rsp_rdata;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [AW-1:0]          mem_addr;
  logic                   mem_wen;
  logic [DW-1:0]          mem_wdata;
  logic [DW/8-1:0]        mem_wstrb;
  logic                   mem_rsp_valid;
  logic [DW-1:0]          mem_rsp_rdata;

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb
  );

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter of N_CH requesters onto one SRAM port, with an in-order ID FIFO that routes responses.
// Defining SRAM_ARB_PERF_EN adds the per-channel handshake counters and the stall-cycle counter.
module sram_port_arbiter #(
  parameter int N_CH  = 2,
  parameter int AW    = 32,
  parameter int DW    = 64,
  parameter int OUTST = 4
) (
  input  logic                clk,
  input  logic                nRst,
  sram_port_arbiter_if.slave  bus
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [N_CH*32-1:0]  perf_grant_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);
  localparam int CW   = $clog2(N_CH);
  localparam int PW   = $clog2(OUTST);
  localparam int CNTW = PW + 1;
  localparam int SW   = DW / 8;

  logic [CW-1:0]   r_lastGrant;
  logic            r_hold;
  logic [CW-1:0]   r_holdCh;
  logic [CW-1:0]   r_idFifo [OUTST];
  logic [PW-1:0]   r_wPtr;
  logic [PW-1:0]   r_rPtr;
  logic [CNTW-1:0] r_count;

  logic [CW-1:0]   w_rrGrant;
  logic [CW-1:0]   w_grant;
  logic [CW-1:0]   w_head;
  logic            w_credit;
  logic            w_memValid;
  logic            w_push;
  logic            w_pop;
  logic [N_CH-1:0] w_reqReady;
  logic [N_CH-1:0] w_rspValid;

  // Search starts one past the last granted channel and wraps around.
  always_comb begin : rrSearch
    int   idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    w_rrGrant = r_lastGrant;
    for (int k = 1; k <= N_CH; k++) begin
      idx = int'(r_lastGrant) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && bus.req_valid[CW'(idx)]) begin
        found     = 1'b1;
        w_rrGrant = CW'(idx);
      end
    end
  end

  // Credit is taken from the registered count, so a pop at full credit enables issue only in the next cycle.
  assign w_grant    = (r_hold && bus.req_valid[r_holdCh]) ? r_holdCh : w_rrGrant;
  assign w_credit   = nRst && (r_count < CNTW'(OUTST));
  assign w_memValid = w_credit && (|bus.req_valid);
  assign w_push     = w_memValid && bus.mem_req_ready;
  assign w_pop      = bus.mem_rsp_valid && (r_count != '0);
  assign w_head     = r_idFifo[r_rPtr];

  always_comb begin
    w_reqReady = '0;
    w_rspValid = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_reqReady[i] = w_push && (w_grant == CW'(i));
      w_rspValid[i] = w_pop && (w_head == CW'(i));
    end
  end

  assign bus.req_ready     = w_reqReady;
  assign bus.rsp_valid     = w_rspValid;
  assign bus.rsp_rdata     = bus.mem_rsp_rdata;
  assign bus.mem_req_valid = w_memValid;
  assign bus.mem_addr      = bus.req_addr[int'(w_grant)*AW +: AW];
  assign bus.mem_wen       = bus.req_wen[w_grant];
  assign bus.mem_wdata     = bus.req_wdata[int'(w_grant)*DW +: DW];
  assign bus.mem_wstrb     = bus.req_wstrb[int'(w_grant)*SW +: SW];

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_lastGrant <= CW'(N_CH - 1);
      r_hold      <= 1'b0;
      r_holdCh    <= '0;
      r_wPtr      <= '0;
      r_rPtr      <= '0;
      r_count     <= '0;
    end else begin
      r_hold   <= w_memValid && !bus.mem_req_ready;
      r_holdCh <= w_grant;
      if (w_push) begin
        r_lastGrant <= w_grant;
        r_wPtr      <= r_wPtr + 1'b1;
      end
      if (w_pop) r_rPtr <= r_rPtr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_idFifo[r_wPtr] <= w_grant;
  end

`ifdef SRAM_ARB_PERF_EN
  logic [31:0] r_grantCnt [N_CH];
  logic [31:0] r_stallCnt;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < N_CH; i++) r_grantCnt[i] <= '0;
      r_stallCnt <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_reqReady[i] && (r_grantCnt[i] != '1)) r_grantCnt[i] <= r_grantCnt[i] + 32'd1;
      end
      if (w_memValid && !bus.mem_req_ready && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + 32'd1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : gPerf
    assign perf_grant_cnt[i*32 +: 32] = r_grantCnt[i];
  end
  assign perf_stall_cnt = r_stallCnt;
`endif
endmodule
